// File: rtl/axis_downsizer.sv
// AXI4-Stream width downsizer: buffers one wide beat and replays it as RATIO
// narrow beats, least-significant slice first, with no bubbles between wide beats.
module axis_downsizer #(
  parameter int S_DATA_BITS = 512,
  parameter int M_DATA_BITS = 64
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [S_DATA_BITS-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [M_DATA_BITS-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready
);

  localparam int RATIO = S_DATA_BITS / M_DATA_BITS;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  if (((S_DATA_BITS % M_DATA_BITS) != 0) || (M_DATA_BITS > S_DATA_BITS)) begin : g_param_check
    $error("axis_downsizer: S_DATA_BITS must be a whole multiple of M_DATA_BITS");
  end

  typedef enum logic {
    ST_EMPTY     = 1'b0,
    ST_SERIALISE = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [S_DATA_BITS-1:0] buf_q, buf_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic full_s;
  logic last_s;
  logic m_fire_s;
  logic s_fire_s;
  logic [M_DATA_BITS-1:0] tdata_s;

  // Handshake terms and the slice selected by the current count.
  always_comb begin
    full_s        = (state_q == ST_SERIALISE);
    last_s        = (cnt_q == CW'(RATIO - 1));
    m_fire_s      = full_s & m_axis_tready;
    s_axis_tready = ~areset & (~full_s | (m_fire_s & last_s));
    s_fire_s      = s_axis_tvalid & s_axis_tready;
    tdata_s       = '0;
    for (int i = 0; i < RATIO; i++) begin
      tdata_s = tdata_s | (buf_q[i*M_DATA_BITS +: M_DATA_BITS] & {M_DATA_BITS{cnt_q == CW'(i)}});
    end
    m_axis_tvalid = full_s;
    m_axis_tdata  = tdata_s;
  end

  // Next-state logic: load on acceptance, step through slices, refill on the last slice.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_EMPTY: begin
        if (s_fire_s) begin
          buf_d   = s_axis_tdata;
          cnt_d   = '0;
          state_d = ST_SERIALISE;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_SERIALISE: begin
        if (m_fire_s) begin
          if (last_s) begin
            cnt_d = '0;
            if (s_fire_s) begin
              buf_d   = s_axis_tdata;
              state_d = ST_SERIALISE;
            end else begin
              state_d = ST_EMPTY;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = ST_SERIALISE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // State registers with synchronous reset; a reset drops any partial wide beat.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ST_EMPTY;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_axis_downsizer.sv
// Directed bench for axis_downsizer: a 256->64 instance and a 64->64 (RATIO=1) instance.
module tb_axis_downsizer;

  logic         aclk = 1'b0;
  logic         areset;

  logic [255:0] a_s_tdata;
  logic         a_s_tvalid, a_s_tready;
  logic [63:0]  a_m_tdata;
  logic         a_m_tvalid, a_m_tready;

  logic [63:0]  b_s_tdata;
  logic         b_s_tvalid, b_s_tready;
  logic [63:0]  b_m_tdata;
  logic         b_m_tvalid, b_m_tready;

  int checks = 0;
  int fails  = 0;

  always #5 aclk = ~aclk;

  axis_downsizer #(.S_DATA_BITS(256), .M_DATA_BITS(64)) u_dut4 (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(a_s_tdata), .s_axis_tvalid(a_s_tvalid), .s_axis_tready(a_s_tready),
    .m_axis_tdata(a_m_tdata), .m_axis_tvalid(a_m_tvalid), .m_axis_tready(a_m_tready)
  );

  axis_downsizer #(.S_DATA_BITS(64), .M_DATA_BITS(64)) u_dut1 (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(b_s_tdata), .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready),
    .m_axis_tdata(b_m_tdata), .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    a_s_tvalid = 1'b1; a_s_tdata = {4{64'hDEAD_BEEF_0000_0001}}; a_m_tready = 1'b0;
    b_s_tvalid = 1'b1; b_s_tdata = 64'hDEAD_BEEF_0000_0002;      b_m_tready = 1'b0;
    tick(); tick();
    @(negedge aclk);
    checks++; if (a_m_tvalid !== 1'b0)  begin fails++; $display("FAIL reset_m_tvalid got %b want 0", a_m_tvalid); end
    checks++; if (a_m_tdata !== 64'h0)  begin fails++; $display("FAIL reset_m_tdata got %h want 0", a_m_tdata); end
    checks++; if (a_s_tready !== 1'b0)  begin fails++; $display("FAIL reset_s_tready got %b want 0", a_s_tready); end
    checks++; if (b_s_tready !== 1'b0)  begin fails++; $display("FAIL reset_r1_s_tready got %b want 0", b_s_tready); end
    tick();
    areset = 1'b0; a_s_tvalid = 1'b0; b_s_tvalid = 1'b0;
    @(negedge aclk);
    checks++; if (a_s_tready !== 1'b1)  begin fails++; $display("FAIL release_s_tready got %b want 1", a_s_tready); end
    checks++; if (a_m_tvalid !== 1'b0)  begin fails++; $display("FAIL release_m_tvalid got %b want 0", a_m_tvalid); end
    checks++; if (b_m_tvalid !== 1'b0)  begin fails++; $display("FAIL release_r1_m_tvalid got %b want 0", b_m_tvalid); end
  endtask

  task automatic test_single_beat();
    logic [63:0] exp_sl [4];
    exp_sl[0] = 64'h1111_1111_1111_1111; exp_sl[1] = 64'h2222_2222_2222_2222;
    exp_sl[2] = 64'h3333_3333_3333_3333; exp_sl[3] = 64'h4444_4444_4444_4444;
    tick();
    a_s_tdata = {exp_sl[3], exp_sl[2], exp_sl[1], exp_sl[0]}; a_s_tvalid = 1'b1; a_m_tready = 1'b1;
    @(negedge aclk);
    checks++; if (a_s_tready !== 1'b1) begin fails++; $display("FAIL single_accept got %b want 1", a_s_tready); end
    tick();
    a_s_tvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      checks++; if (a_m_tvalid !== 1'b1) begin fails++; $display("FAIL single_tvalid[%0d] got %b want 1", k, a_m_tvalid); end
      checks++; if (a_m_tdata !== exp_sl[k]) begin fails++; $display("FAIL single_tdata[%0d] got %h want %h", k, a_m_tdata, exp_sl[k]); end
      checks++; if (a_s_tready !== (k == 3)) begin fails++; $display("FAIL single_s_tready[%0d] got %b want %b", k, a_s_tready, (k == 3)); end
      tick();
    end
    @(negedge aclk);
    checks++; if (a_m_tvalid !== 1'b0) begin fails++; $display("FAIL single_drain got %b want 0", a_m_tvalid); end
  endtask

  // Streams n wide beats; rnd selects 50% random m_tready instead of constant 1.
  task automatic run_stream4(input int n, input bit rnd, input string tag);
    logic [63:0]  exp_q [$];
    logic [255:0] beats [$];
    logic [63:0]  sl [4];
    logic [63:0]  stall_data;
    bit stall_prev = 1'b0;
    int in_i = 0, out_n = 0, cyc = 0, first_acc = -1, first_out = -1, last_out = -1;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        sl[j] = 64'h5A00_0000_0000_0000 | (64'(i) << 16) | 64'(j);
        exp_q.push_back(sl[j]);
      end
      beats.push_back({sl[3], sl[2], sl[1], sl[0]});
    end
    stall_data = '0;
    while (out_n < n * 4 && cyc < 2000) begin
      tick();
      a_s_tvalid = (in_i < n);
      a_s_tdata  = (in_i < n) ? beats[in_i] : '0;
      a_m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge aclk);
      if (stall_prev) begin
        checks++;
        if (a_m_tvalid !== 1'b1 || a_m_tdata !== stall_data) begin
          fails++; $display("FAIL %s_stall_hold got %b/%h want 1/%h", tag, a_m_tvalid, a_m_tdata, stall_data);
        end
      end
      if (a_m_tvalid && a_m_tready) begin
        checks++;
        if (a_m_tdata !== exp_q[out_n]) begin
          fails++; $display("FAIL %s_data[%0d] got %h want %h", tag, out_n, a_m_tdata, exp_q[out_n]);
        end
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        out_n++;
      end
      stall_prev = a_m_tvalid && !a_m_tready;
      stall_data = a_m_tdata;
      if (a_s_tvalid && a_s_tready) begin
        if (first_acc < 0) first_acc = cyc;
        in_i++;
      end
      cyc++;
    end
    a_s_tvalid = 1'b0;
    checks++; if (out_n != n * 4) begin fails++; $display("FAIL %s_count got %0d want %0d", tag, out_n, n * 4); end
    if (!rnd) begin
      checks++; if (first_out != first_acc + 1) begin fails++; $display("FAIL %s_latency got %0d want %0d", tag, first_out, first_acc + 1); end
      checks++; if (last_out - first_out != n * 4 - 1) begin fails++; $display("FAIL %s_bubbles got span %0d want %0d", tag, last_out - first_out, n * 4 - 1); end
    end
    tick();
    @(negedge aclk);
    checks++; if (a_m_tvalid !== 1'b0) begin fails++; $display("FAIL %s_no_extra got %b want 0", tag, a_m_tvalid); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] old_sl [4];
    logic [63:0] new_sl [4];
    for (int j = 0; j < 4; j++) begin
      old_sl[j] = 64'h0101_0101_0101_0100 | 64'(j);
      new_sl[j] = 64'hAAAA_AAAA_AAAA_AAA0 | 64'(j);
    end
    tick();
    a_s_tdata = {old_sl[3], old_sl[2], old_sl[1], old_sl[0]}; a_s_tvalid = 1'b1; a_m_tready = 1'b1;
    tick();
    a_s_tvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge aclk);
      checks++; if (a_m_tdata !== old_sl[k]) begin fails++; $display("FAIL rstmid_pre[%0d] got %h want %h", k, a_m_tdata, old_sl[k]); end
      tick();
    end
    areset = 1'b1; a_m_tready = 1'b0; a_s_tvalid = 1'b1;
    a_s_tdata = {new_sl[3], new_sl[2], new_sl[1], new_sl[0]};
    @(negedge aclk);
    checks++; if (a_s_tready !== 1'b0) begin fails++; $display("FAIL rstmid_s_tready got %b want 0", a_s_tready); end
    tick();
    areset = 1'b0; a_s_tvalid = 1'b0;
    @(negedge aclk);
    checks++; if (a_m_tvalid !== 1'b0) begin fails++; $display("FAIL rstmid_tvalid got %b want 0", a_m_tvalid); end
    checks++; if (a_m_tdata !== 64'h0) begin fails++; $display("FAIL rstmid_tdata got %h want 0", a_m_tdata); end
    tick();
    a_s_tvalid = 1'b1; a_m_tready = 1'b1;
    tick();
    a_s_tvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      checks++;
      if (a_m_tvalid !== 1'b1 || a_m_tdata !== new_sl[k]) begin
        fails++; $display("FAIL rstmid_post[%0d] got %b/%h want 1/%h", k, a_m_tvalid, a_m_tdata, new_sl[k]);
      end
      tick();
    end
    @(negedge aclk);
    checks++; if (a_m_tvalid !== 1'b0) begin fails++; $display("FAIL rstmid_stale got %b/%h want 0", a_m_tvalid, a_m_tdata); end
  endtask

  task automatic test_gaps();
    bit          pat [6];
    logic [63:0] dat [6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int c = 0; c < 6; c++) dat[c] = 64'h6A90_0000_0000_0000 | 64'(c);
    for (int c = 0; c < 6; c++) begin
      tick();
      b_s_tvalid = pat[c]; b_s_tdata = dat[c]; b_m_tready = 1'b1;
      @(negedge aclk);
      if (c > 0) begin
        checks++;
        if (b_m_tvalid !== pat[c-1]) begin fails++; $display("FAIL gaps_tvalid[%0d] got %b want %b", c, b_m_tvalid, pat[c-1]); end
        if (pat[c-1]) begin
          checks++;
          if (b_m_tdata !== dat[c-1]) begin fails++; $display("FAIL gaps_tdata[%0d] got %h want %h", c, b_m_tdata, dat[c-1]); end
        end
      end
    end
    b_s_tvalid = 1'b0;
  endtask

  task automatic run_stream1(input int n, input bit rnd, input string tag);
    logic [63:0] exp_q [$];
    int in_i = 0, out_n = 0, cyc = 0, first_acc = -1, first_out = -1, last_out = -1;
    for (int i = 0; i < n; i++) exp_q.push_back({$urandom(), $urandom()});
    while (out_n < n && cyc < 2000) begin
      tick();
      b_s_tvalid = (in_i < n);
      b_s_tdata  = (in_i < n) ? exp_q[in_i] : '0;
      b_m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge aclk);
      if (b_m_tvalid && b_m_tready) begin
        checks++;
        if (b_m_tdata !== exp_q[out_n]) begin
          fails++; $display("FAIL %s_data[%0d] got %h want %h", tag, out_n, b_m_tdata, exp_q[out_n]);
        end
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        out_n++;
      end
      if (b_s_tvalid && b_s_tready) begin
        if (first_acc < 0) first_acc = cyc;
        in_i++;
      end
      cyc++;
    end
    b_s_tvalid = 1'b0;
    checks++; if (out_n != n) begin fails++; $display("FAIL %s_count got %0d want %0d", tag, out_n, n); end
    if (!rnd) begin
      checks++; if (first_out != first_acc + 1) begin fails++; $display("FAIL %s_latency got %0d want %0d", tag, first_out, first_acc + 1); end
      checks++; if (last_out - first_out != n - 1) begin fails++; $display("FAIL %s_throughput got span %0d want %0d", tag, last_out - first_out, n - 1); end
    end
    tick();
    @(negedge aclk);
    checks++; if (b_m_tvalid !== 1'b0) begin fails++; $display("FAIL %s_no_extra got %b want 0", tag, b_m_tvalid); end
  endtask

  initial begin
    areset = 1'b1;
    a_s_tdata = '0; a_s_tvalid = 1'b0; a_m_tready = 1'b0;
    b_s_tdata = '0; b_s_tvalid = 1'b0; b_m_tready = 1'b0;
    test_reset();
    test_single_beat();
    run_stream4(8, 1'b0, "stream");
    run_stream4(16, 1'b1, "backpressure");
    test_reset_mid();
    test_gaps();
    run_stream1(100, 1'b1, "r1_random");
    run_stream1(12, 1'b0, "r1_full");
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
